// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory-access controller and its device bus.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } state_e;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned BE_W        = 4;
   localparam int unsigned WADDR_W     = 30;
   localparam int unsigned NUM_REGIONS = 3;

   localparam int unsigned REG_ROM = 0;
   localparam int unsigned REG_RAM = 1;
   localparam int unsigned REG_IO  = 2;

   localparam logic [ADDR_W-1:0] DEF_ROM_BASE = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] DEF_ROM_MASK = 32'hFFFF_C000;
   localparam logic [ADDR_W-1:0] DEF_RAM_BASE = 32'h4000_0000;
   localparam logic [ADDR_W-1:0] DEF_RAM_MASK = 32'hFFFF_0000;
   localparam logic [ADDR_W-1:0] DEF_IO_BASE  = 32'h8000_0000;
   localparam logic [ADDR_W-1:0] DEF_IO_MASK  = 32'hFFFF_F000;

   function automatic logic region_hit(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU memory-access port plus word-addressed device bus, seen from the environment (master)
// and from the controller (slave).
interface mem_access_ctrl_if;
   import cpu_bus_pkg::*;

   logic [ADDR_W-1:0]             ma_addr;
   logic [DATA_W-1:0]             ma_data_out;
   logic                          ma_rd_req;
   logic                          ma_wr_req;
   logic [BE_W-1:0]               ma_data_mask;
   logic [DATA_W-1:0]             ma_data_in;
   logic                          ma_done;
   logic                          ma_timeout;
   logic [WADDR_W-1:0]            dev_addr;
   logic [DATA_W-1:0]             dev_wdata;
   logic [BE_W-1:0]               dev_be;
   logic                          dev_rd;
   logic                          dev_wr;
   logic [NUM_REGIONS-1:0]        dev_sel;
   logic [NUM_REGIONS-1:0]        dev_ack;
   logic [NUM_REGIONS*DATA_W-1:0] dev_rdata;

   modport master (
      output ma_addr, ma_data_out, ma_rd_req, ma_wr_req, ma_data_mask, dev_ack, dev_rdata,
      input  ma_data_in, ma_done, ma_timeout, dev_addr, dev_wdata, dev_be, dev_rd, dev_wr,
             dev_sel
   );

   modport slave (
      input  ma_addr, ma_data_out, ma_rd_req, ma_wr_req, ma_data_mask, dev_ack, dev_rdata,
      output ma_data_in, ma_done, ma_timeout, dev_addr, dev_wdata, dev_be, dev_rd, dev_wr,
             dev_sel
   );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering between low-aligned CPU data/mask and lane-aligned bus data/enables.
module mem_lane_align
   import cpu_bus_pkg::*;
(
   input  logic [BE_W-1:0]   mask_i,
   input  logic [1:0]        off_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [BE_W-1:0]   be_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              ovf_o
);

   localparam int unsigned BE_EXT_W = 2 * BE_W - 1;

   logic [BE_EXT_W-1:0] be_wide;
   logic [4:0]          bit_off;

   assign bit_off = {off_i, 3'b000};
   assign be_wide = BE_EXT_W'(mask_i) << off_i;
   assign be_o    = be_wide[BE_W-1:0];
   // Any enable pushed past lane 3 means the access straddles a word.
   assign ovf_o   = |be_wide[BE_EXT_W-1:BE_W];
   assign wdata_o = wdata_i << bit_off;
   assign rdata_o = rdata_i >> bit_off;

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns each CPU memory request into one device-bus transaction with region decode,
// lane steering, and a bounded wait for acknowledge.
module mem_access_ctrl
   import cpu_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ROM_BASE       = DEF_ROM_BASE,
   parameter logic [ADDR_W-1:0] ROM_MASK       = DEF_ROM_MASK,
   parameter logic [ADDR_W-1:0] RAM_BASE       = DEF_RAM_BASE,
   parameter logic [ADDR_W-1:0] RAM_MASK       = DEF_RAM_MASK,
   parameter logic [ADDR_W-1:0] IO_BASE        = DEF_IO_BASE,
   parameter logic [ADDR_W-1:0] IO_MASK        = DEF_IO_MASK,
   parameter int unsigned       TIMEOUT_CYCLES = 16
) (
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.slave  bus
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                   state_q, state_d;
   logic [1:0]               off_q, off_d;
   logic [WADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]        wdata_q, wdata_d;
   logic [BE_W-1:0]          be_q, be_d;
   logic [NUM_REGIONS-1:0]   sel_q, sel_d;
   logic                     rd_q, rd_d;
   logic                     wr_q, wr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]        rdata_q, rdata_d;
   logic                     done_q, done_d;
   logic                     tmo_q, tmo_d;

   logic                     req;
   logic                     req_rd;
   logic [NUM_REGIONS-1:0]   hit_sel;
   logic                     fault;
   logic                     ack;
   logic                     cnt_expired;
   logic [1:0]               align_off;
   logic [DATA_W-1:0]        dev_rdata_sel;
   logic [BE_W-1:0]          be_shift;
   logic [DATA_W-1:0]        wdata_shift;
   logic [DATA_W-1:0]        rdata_shift;
   logic                     be_ovf;

   assign req    = bus.ma_rd_req | bus.ma_wr_req;
   assign req_rd = bus.ma_rd_req;

   // One-hot region decode; fixed priority only matters if regions are configured to overlap.
   always_comb begin
      hit_sel = '0;
      if (region_hit(bus.ma_addr, ROM_BASE, ROM_MASK)) begin
         hit_sel[REG_ROM] = 1'b1;
      end else if (region_hit(bus.ma_addr, RAM_BASE, RAM_MASK)) begin
         hit_sel[REG_RAM] = 1'b1;
      end else if (region_hit(bus.ma_addr, IO_BASE, IO_MASK)) begin
         hit_sel[REG_IO] = 1'b1;
      end
   end

   assign fault = ~|hit_sel | (~req_rd & hit_sel[REG_ROM]) | be_ovf;

   always_comb begin
      dev_rdata_sel = '0;
      if (sel_q[REG_ROM]) begin
         dev_rdata_sel = bus.dev_rdata[REG_ROM*DATA_W +: DATA_W];
      end else if (sel_q[REG_RAM]) begin
         dev_rdata_sel = bus.dev_rdata[REG_RAM*DATA_W +: DATA_W];
      end else if (sel_q[REG_IO]) begin
         dev_rdata_sel = bus.dev_rdata[REG_IO*DATA_W +: DATA_W];
      end
   end

   assign ack         = |(bus.dev_ack & sel_q);
   assign cnt_expired = (cnt_q == CNT_LAST);
   // Write path aligns the live request; read path aligns with the latched offset.
   assign align_off   = (state_q == ST_IDLE) ? bus.ma_addr[1:0] : off_q;

   mem_lane_align u_lane_align (
      .mask_i  (bus.ma_data_mask),
      .off_i   (align_off),
      .wdata_i (bus.ma_data_out),
      .rdata_i (dev_rdata_sel),
      .be_o    (be_shift),
      .wdata_o (wdata_shift),
      .rdata_o (rdata_shift),
      .ovf_o   (be_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = fault ? ST_RESPOND : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (ack || cnt_expired) begin
               state_d = ST_RESPOND;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Ack is tested before expiry so a last-cycle ack still completes normally.
   always_comb begin
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      sel_d   = sel_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               off_d   = bus.ma_addr[1:0];
               addr_d  = bus.ma_addr[ADDR_W-1:2];
               wdata_d = wdata_shift;
               be_d    = be_shift;
               sel_d   = hit_sel;
               cnt_d   = '0;
               if (fault) begin
                  tmo_d = 1'b1;
               end else begin
                  rd_d = req_rd;
                  wr_d = ~req_rd;
               end
            end
         end
         ST_ACCESS: begin
            if (ack) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               rdata_d = rdata_shift;
               done_d  = 1'b1;
            end else if (cnt_expired) begin
               rd_d  = 1'b0;
               wr_d  = 1'b0;
               tmo_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESPOND: begin
            sel_d = '0;
            be_d  = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         sel_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.ma_data_in = rdata_q;
   assign bus.ma_done    = done_q;
   assign bus.ma_timeout = tmo_q;
   assign bus.dev_addr   = addr_q;
   assign bus.dev_wdata  = wdata_q;
   assign bus.dev_be     = be_q;
   assign bus.dev_rd     = rd_q;
   assign bus.dev_wr     = wr_q;
   assign bus.dev_sel    = sel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized transactions against an address-range / byte-count model of the
// memory-access controller, with a cycle-by-cycle device responder.
module tb_mem_access_ctrl;

   localparam int TIMEOUT = 16;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] last_rdata = '0;

   mem_access_ctrl_if bus_if ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Address ranges written out directly rather than as base/mask pairs.
   function automatic int region_of(input logic [31:0] a);
      if (a < 32'h0000_4000) return 0;
      if (a >= 32'h4000_0000 && a < 32'h4001_0000) return 1;
      if (a >= 32'h8000_0000 && a < 32'h8000_1000) return 2;
      return -1;
   endfunction

   function automatic int bytes_of(input logic [3:0] m);
      return (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : 4;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_ctl"}, 64'({bus_if.dev_rd, bus_if.dev_wr, bus_if.ma_done, bus_if.ma_timeout,
                              bus_if.dev_sel, bus_if.dev_be}), 64'(0));
      chk({tag, "_din"}, 64'(bus_if.ma_data_in), 64'(last_rdata));
   endtask

   // Starts one request with the DUT idle; ack_delay = strobe cycles before ack (-1: never).
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] data, input logic rd,
                         input logic wr, input logic [3:0] mask, input int ack_delay,
                         input bit spur, input logic [95:0] rd_all);
      int          region, off, nb, n_strobe;
      bit          fault, acked;
      logic [2:0]  exp_sel;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, dr;
      logic        is_rd;
      region  = region_of(addr);
      off     = int'(addr[1:0]);
      nb      = bytes_of(mask);
      is_rd   = rd;
      fault   = (region < 0) || (!is_rd && region == 0) || (off + nb > 4);
      exp_sel = (region >= 0) ? 3'(1 << region) : 3'b000;
      exp_be  = 4'(((1 << nb) - 1) << off);
      exp_wd  = data << (8 * off);
      acked   = (ack_delay >= 0) && (ack_delay < TIMEOUT);
      n_strobe = acked ? ack_delay + 1 : TIMEOUT;

      bus_if.ma_addr      = addr;
      bus_if.ma_data_out  = data;
      bus_if.ma_rd_req    = rd;
      bus_if.ma_wr_req    = wr;
      bus_if.ma_data_mask = mask;
      bus_if.dev_rdata    = rd_all;
      @(posedge clk); #1;

      if (fault) begin
         chk("fault_resp", 64'({bus_if.dev_rd, bus_if.dev_wr, bus_if.ma_done, bus_if.ma_timeout}),
             64'(4'b0001));
         bus_if.ma_rd_req = 1'b0;
         bus_if.ma_wr_req = 1'b0;
         @(posedge clk); #1;
         chk_idle("fault_idle");
         return;
      end

      for (int k = 1; k <= n_strobe; k++) begin
         chk("strobe", 64'({bus_if.dev_rd, bus_if.dev_wr, bus_if.ma_done, bus_if.ma_timeout}),
             64'({is_rd, ~is_rd, 2'b00}));
         if (k == 1) begin
            chk("sel_addr", 64'({bus_if.dev_sel, bus_if.dev_addr}), 64'({exp_sel, addr[31:2]}));
            chk("be_wdata", 64'({bus_if.dev_be, bus_if.dev_wdata}), 64'({exp_be, exp_wd}));
         end
         if (acked && k == n_strobe)
            bus_if.dev_ack = exp_sel | (spur ? 3'($urandom) : 3'b000);
         else
            bus_if.dev_ack = spur ? (3'($urandom) & ~exp_sel) : 3'b000;
         @(posedge clk); #1;
      end
      bus_if.dev_ack = 3'b000;

      chk("resp", 64'({bus_if.dev_rd, bus_if.dev_wr, bus_if.ma_done, bus_if.ma_timeout}),
          64'({2'b00, acked, ~acked}));
      if (acked) begin
         dr = rd_all[region*32 +: 32];
         last_rdata = dr >> (8 * off);
      end
      chk("resp_din", 64'(bus_if.ma_data_in), 64'(last_rdata));
      bus_if.ma_rd_req = 1'b0;
      bus_if.ma_wr_req = 1'b0;
      @(posedge clk); #1;
      chk_idle("post_idle");
   endtask

   logic [95:0] rnd_all;
   logic [31:0] raddr;
   logic [3:0]  rmask;
   int          op, rgn, dly;

   initial begin
      rst = 1'b1;
      bus_if.ma_addr      = '0;
      bus_if.ma_data_out  = '0;
      bus_if.ma_rd_req    = 1'b0;
      bus_if.ma_wr_req    = 1'b0;
      bus_if.ma_data_mask = '0;
      bus_if.dev_ack      = '0;
      bus_if.dev_rdata    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      chk("reset_addr", 64'(bus_if.dev_addr), 64'(0));
      chk("reset_wdata", 64'(bus_if.dev_wdata), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // RAM word read, zero-wait.
      do_txn(32'h4000_0010, 32'h0, 1'b1, 1'b0, 4'b1111, 0, 1'b0,
             {32'h0, 32'hDEAD_BEEF, 32'h0});
      chk("ram_word_din", 64'(bus_if.ma_data_in), 64'(32'hDEAD_BEEF));
      // Byte store to lane 3.
      do_txn(32'h4000_0003, 32'h0000_00A5, 1'b0, 1'b1, 4'b0001, 0, 1'b0, '0);
      // IO halfword read from upper half.
      do_txn(32'h8000_0002, 32'h0, 1'b1, 1'b0, 4'b0011, 2, 1'b1,
             {32'h1234_5678, 32'h0, 32'h0});
      chk("io_half_din", 64'(bus_if.ma_data_in), 64'(32'h0000_1234));
      // Unmapped read, ROM write, straddling accesses.
      do_txn(32'hC000_0000, 32'h0, 1'b1, 1'b0, 4'b1111, 0, 1'b0, '0);
      do_txn(32'h0000_0100, 32'h1, 1'b0, 1'b1, 4'b1111, 0, 1'b0, '0);
      do_txn(32'h4000_0001, 32'h0, 1'b1, 1'b0, 4'b1111, 0, 1'b0, '0);
      do_txn(32'h4000_0003, 32'h0, 1'b0, 1'b1, 4'b0011, 0, 1'b0, '0);
      // Both requests to ROM behaves as a read.
      do_txn(32'h0000_0104, 32'h0, 1'b1, 1'b1, 4'b1111, 1, 1'b0,
             {32'h0, 32'h0, 32'hCAFE_F00D});
      // Never-acking RAM, then ack on the final permitted cycle.
      do_txn(32'h4000_0020, 32'h0, 1'b1, 1'b0, 4'b1111, -1, 1'b1, {3{32'h5555_AAAA}});
      do_txn(32'h4000_0024, 32'h0, 1'b1, 1'b0, 4'b1111, TIMEOUT - 1, 1'b0,
             {32'h0, 32'h0BAD_F00D, 32'h0});

      // Reset in the middle of an access.
      bus_if.ma_addr      = 32'h4000_0030;
      bus_if.ma_data_mask = 4'b1111;
      bus_if.ma_rd_req    = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      last_rdata = '0;
      chk_idle("rst_access");
      chk("rst_addr", 64'(bus_if.dev_addr), 64'(0));
      bus_if.ma_rd_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_idle("rst_after");
      do_txn(32'h8000_0FFC, 32'h0, 1'b1, 1'b0, 4'b1111, 0, 1'b0,
             {32'h7777_8888, 32'h0, 32'h0});

      // Randomized traffic across regions, widths, offsets and ack latencies.
      for (int t = 0; t < 60; t++) begin
         rgn = int'($urandom_range(0, 3));
         case (rgn)
            0:       raddr = $urandom & 32'h0000_3FFF;
            1:       raddr = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
            2:       raddr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            default: raddr = 32'hC000_0000 | ($urandom & 32'h0FFF_FFFF);
         endcase
         op = int'($urandom_range(0, 2));
         case ($urandom_range(0, 2))
            0:       rmask = 4'b0001;
            1:       rmask = 4'b0011;
            default: rmask = 4'b1111;
         endcase
         dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 17));
         rnd_all = {$urandom, $urandom, $urandom};
         do_txn(raddr, $urandom, (op != 1), (op != 0), rmask, dly, 1'($urandom), rnd_all);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
